controle_display: RTL and testbench

CONTROLE_DISPLAY -- requirements
Module: controle_display

---
 rtl/controle_display_pkg.sv | 47 ++++
 rtl/controle_display_if.sv | 23 ++
 rtl/controle_display_divisor_varredura.sv | 41 ++++
 rtl/controle_display.sv | 161 ++++++++++++++++
 tb/tb_controle_display.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/controle_display_pkg.sv
// Shared symbol codes, message ids and FSM encodings for the 4-digit display controller.
// Also holds the small decode helpers used by the top level.
package display_pkg;

   localparam logic [3:0] COD_C     = 4'd6;
   localparam logic [3:0] COD_E     = 4'd7;
   localparam logic [3:0] COD_I     = 4'd8;
   localparam logic [3:0] COD_N     = 4'd9;
   localparam logic [3:0] COD_P     = 4'd10;
   localparam logic [3:0] COD_BLANK = 4'd15;

   localparam logic [2:0] CONT_INICIO = 3'd5;
   localparam logic [2:0] CRED_MAX    = 3'd5;

   typedef enum logic [2:0] {
      MSG_CREDITO  = 3'd0,
      MSG_PIN      = 3'd1,
      MSG_ERRO     = 3'd2,
      MSG_APAGADO  = 3'd3,
      MSG_CONTAGEM = 3'd4
   } msg_e;

   typedef enum logic [1:0] {
      ST_APAGADO  = 2'd0,
      ST_FIXO     = 2'd1,
      ST_PISCA    = 2'd2,
      ST_CONTAGEM = 2'd3
   } state_e;

   // Unused ids 5-7 fold onto the blank message.
   function automatic msg_e decode_msg(input logic [2:0] sel);
      msg_e m;
      case (sel)
         3'd0:    m = MSG_CREDITO;
         3'd1:    m = MSG_PIN;
         3'd2:    m = MSG_ERRO;
         3'd4:    m = MSG_CONTAGEM;
         default: m = MSG_APAGADO;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] cod_credito(input logic [2:0] cred);
      return (cred > CRED_MAX) ? COD_BLANK : {1'b0, cred};
   endfunction

endpackage

// File: rtl/controle_display_if.sv
// Request/acknowledge and display-drive bundle between the controller and its user.
// The slave side is the controller; the master side issues loads and watches the display.
interface controle_display_if;

   logic       load;
   logic [2:0] msg_sel;
   logic [2:0] credito;
   logic       ack;
   logic       done;
   logic [3:0] code;
   logic [3:0] an;

   modport master (
      output load, msg_sel, credito,
      input  ack, done, code, an
   );

   modport slave (
      input  load, msg_sel, credito,
      output ack, done, code, an
   );

endinterface

// File: rtl/controle_display_divisor_varredura.sv
// Scan-rate prescaler and digit index for the multiplexed display.
// frame_o marks the step where the index wraps from 3 back to 0.
module divisor_varredura
   import display_pkg::*;
#(
   parameter int DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] idx_o,
   output logic       frame_o
);

   localparam int             PW         = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic          tick;

   assign tick = (presc_q == PRESC_LAST);

   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      idx_d   = tick ? idx_q + 2'd1 : idx_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   assign idx_o   = idx_q;
   assign frame_o = tick && (idx_q == 2'd3);

endmodule

// File: rtl/controle_display.sv
// Message controller for a 4-digit multiplexed 7-segment display: fixed text,
// blinking error, and a 5..0 countdown that falls back to the credit screen.
module controle_display
   import display_pkg::*;
#(
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 125
) (
   input  logic               clk,
   input  logic               rst,
   controle_display_if.slave  bus
);

   localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [1:0]    idx_w;
   logic          frame_w;

   state_e        state_q, state_d;
   msg_e          msg_q, msg_d;
   logic [2:0]    cred_q, cred_d;
   logic [2:0]    count_q, count_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          ack_q, ack_d;
   logic          done_q, done_d;
   logic [3:0]    code_q, code_d;
   logic [3:0]    an_q, an_d;
   logic          blink_toggle;
   msg_e          msg_in;

   divisor_varredura #(.DIV(DIV)) u_varredura (
      .clk     (clk),
      .rst     (rst),
      .idx_o   (idx_w),
      .frame_o (frame_w)
   );

   assign blink_toggle = frame_w && (bcnt_q == BLINK_LAST);
   assign msg_in       = decode_msg(bus.msg_sel);

   // Next state: a load always wins over blink/countdown events in the same cycle.
   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      cred_d  = cred_q;
      count_d = count_q;
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;

      if (frame_w) begin
         if (blink_toggle) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d  = bcnt_q + BW'(1);
         end
      end

      if (bus.load) begin
         ack_d   = 1'b1;
         bcnt_d  = '0;
         phase_d = 1'b1;
         msg_d   = msg_in;
         cred_d  = bus.credito;
         case (msg_in)
            MSG_CREDITO,
            MSG_PIN:      state_d = ST_FIXO;
            MSG_ERRO:     state_d = ST_PISCA;
            MSG_CONTAGEM: begin
               state_d = ST_CONTAGEM;
               count_d = CONT_INICIO;
            end
            default:      state_d = ST_APAGADO;
         endcase
      end else if (state_q == ST_CONTAGEM && blink_toggle) begin
         if (count_q == 3'd0) begin
            state_d = ST_FIXO;
            msg_d   = MSG_CREDITO;
            done_d  = 1'b1;
         end else begin
            count_d = count_q - 3'd1;
         end
      end
   end

   // Display content for the digit currently being scanned.
   always_comb begin
      an_d   = 4'b0001 << idx_w;
      code_d = COD_BLANK;
      case (state_q)
         ST_FIXO: begin
            if (msg_q == MSG_PIN) begin
               case (idx_w)
                  2'd3:    code_d = COD_P;
                  2'd2:    code_d = COD_I;
                  2'd1:    code_d = COD_N;
                  default: code_d = COD_BLANK;
               endcase
            end else begin
               case (idx_w)
                  2'd3:    code_d = COD_C;
                  2'd0:    code_d = cod_credito(cred_q);
                  default: code_d = COD_BLANK;
               endcase
            end
         end
         ST_PISCA: begin
            if (phase_q) begin
               code_d = (idx_w == 2'd3) ? COD_E : COD_BLANK;
            end else begin
               an_d   = 4'b0000;
               code_d = COD_BLANK;
            end
         end
         ST_CONTAGEM: begin
            case (idx_w)
               2'd3:    code_d = COD_C;
               2'd0:    code_d = {1'b0, count_q};
               default: code_d = COD_BLANK;
            endcase
         end
         default: code_d = COD_BLANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_APAGADO;
         msg_q   <= MSG_APAGADO;
         cred_q  <= 3'd0;
         count_q <= 3'd0;
         bcnt_q  <= '0;
         phase_q <= 1'b1;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         code_q  <= COD_BLANK;
         an_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         cred_q  <= cred_d;
         count_q <= count_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         code_q  <= code_d;
         an_q    <= an_d;
      end
   end

   assign bus.ack  = ack_q;
   assign bus.done = done_q;
   assign bus.code = code_q;
   assign bus.an   = an_q;

endmodule

// File: tb/tb_controle_display.sv
// Bench for controle_display with a fast scan (DIV=4) and short blink (2 frames).
// Expected screens are queued when a load is driven and compared over one scan frame.
module tb_controle_display;
   import display_pkg::*;

   localparam int DIV = 4;
   localparam int BF  = 2;

   logic clk = 1'b0;
   logic rst;
   controle_display_if bus ();

   controle_display #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  msg;
      logic [2:0]  cred;
      logic [15:0] exp;
      string       name;
   } vec_t;

   typedef struct {
      logic [15:0] exp;
      string       name;
   } frame_t;

   frame_t sb[$];
   int n_checks = 0;
   int n_err    = 0;
   int done_cnt = 0;

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [2:0] m, input logic [2:0] c, input string name);
      bus.load    = 1'b1;
      bus.msg_sel = m;
      bus.credito = c;
      step();
      bus.load    = 1'b0;
      chk({name, "_ack"}, 32'(bus.ack), 32'd1);
   endtask

   task automatic push_frame(input logic [15:0] e, input string name);
      frame_t f;
      f.exp  = e;
      f.name = name;
      sb.push_back(f);
   endtask

   task automatic check_frame();
      frame_t     f;
      logic [3:0] seen;
      int         p;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      f    = sb.pop_front();
      seen = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         step();
         if (i == 0) chk({f.name, "_ack_low"}, 32'(bus.ack), 32'd0);
         case (bus.an)
            4'b0001: p = 0;
            4'b0010: p = 1;
            4'b0100: p = 2;
            4'b1000: p = 3;
            default: p = -1;
         endcase
         chk({f.name, "_onehot"}, 32'(p >= 0), 32'd1);
         if (p >= 0) begin
            seen[p] = 1'b1;
            chk({f.name, "_code"}, 32'(bus.code), 32'(f.exp[p*4 +: 4]));
         end
      end
      chk({f.name, "_all_pos"}, 32'(seen), 32'hF);
   endtask

   vec_t tbl[10];

   initial begin
      int         k, last, len, d0;
      bit         found, seen_e;
      logic [3:0] an_seq [4];

      tbl[0] = '{3'd0, 3'd3, 16'h6FF3, "cred3"};
      tbl[1] = '{3'd0, 3'd0, 16'h6FF0, "cred0"};
      tbl[2] = '{3'd0, 3'd5, 16'h6FF5, "cred5"};
      tbl[3] = '{3'd0, 3'd6, 16'h6FFF, "cred6"};
      tbl[4] = '{3'd0, 3'd7, 16'h6FFF, "cred7"};
      tbl[5] = '{3'd1, 3'd2, 16'hA89F, "pin"};
      tbl[6] = '{3'd2, 3'd0, 16'h7FFF, "erro_on"};
      tbl[7] = '{3'd3, 3'd4, 16'hFFFF, "apagado"};
      tbl[8] = '{3'd5, 3'd1, 16'hFFFF, "msg5"};
      tbl[9] = '{3'd7, 3'd1, 16'hFFFF, "msg7"};

      bus.load    = 1'b0;
      bus.msg_sel = 3'd0;
      bus.credito = 3'd0;
      rst         = 1'b1;

      // reset values and free-running scan after release
      repeat (3) step();
      chk("rst_code", 32'(bus.code), 32'd15);
      chk("rst_an",   32'(bus.an),   32'd0);
      chk("rst_ack",  32'(bus.ack),  32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      an_seq[0] = 4'b0001; an_seq[1] = 4'b0010; an_seq[2] = 4'b0100; an_seq[3] = 4'b1000;
      for (int d = 0; d < 4; d++) begin
         step();
         chk("scan_an_first", 32'(bus.an), 32'(an_seq[d]));
         chk("scan_code", 32'(bus.code), 32'd15);
         repeat (3) step();
         chk("scan_an_last", 32'(bus.an), 32'(an_seq[d]));
      end

      // table of single-load screens
      for (int t = 0; t < 10; t++) begin
         do_load(tbl[t].msg, tbl[t].cred, tbl[t].name);
         push_frame(tbl[t].exp, tbl[t].name);
         check_frame();
      end

      // ERRO blink: 32 cycles dark, 32 cycles showing E at the leftmost digit
      do_load(3'd2, 3'd0, "blink");
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         if (bus.an == 4'b0000) found = 1'b1;
      end
      chk("blink_off_seen", 32'(found), 32'd1);
      len = 0;
      for (int i = 0; i < 100 && bus.an == 4'b0000; i++) begin
         if (bus.code != 4'd15) chk("blink_off_code", 32'(bus.code), 32'd15);
         len++;
         step();
      end
      chk("blink_off_len", 32'(len), 32'd32);
      len    = 0;
      seen_e = 1'b0;
      for (int i = 0; i < 100 && bus.an != 4'b0000; i++) begin
         if (bus.an == 4'b1000 && bus.code == COD_E) seen_e = 1'b1;
         len++;
         step();
      end
      chk("blink_on_len", 32'(len), 32'd32);
      chk("blink_on_e", 32'(seen_e), 32'd1);

      // countdown 5..0 then done and credit screen
      do_load(3'd4, 3'd2, "cont");
      d0    = done_cnt;
      k     = 0;
      last  = -1;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         step();
         if (bus.done === 1'b1) begin
            found = 1'b1;
         end else if (bus.an == 4'b0001 && int'(bus.code) != last) begin
            if (k < 6) chk("cont_seq", 32'(bus.code), 32'(5 - k));
            else       chk("cont_seq_extra", 32'(bus.code), 32'd99);
            last = int'(bus.code);
            k++;
         end else if (bus.an == 4'b1000) begin
            chk("cont_pos3", 32'(bus.code), 32'(COD_C));
         end
      end
      chk("cont_done_seen", 32'(found), 32'd1);
      chk("cont_steps", 32'(k), 32'd6);
      step();
      chk("cont_done_width", 32'(bus.done), 32'd0);
      chk("cont_done_count", 32'(done_cnt - d0), 32'd1);
      push_frame(16'h6FF2, "cont_end");
      check_frame();

      // abort countdown at count 3 with PIN: no done
      do_load(3'd4, 3'd1, "abort_cont");
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         step();
         if (bus.an == 4'b0001 && bus.code == 4'd3) found = 1'b1;
      end
      chk("abort_reach3", 32'(found), 32'd1);
      d0 = done_cnt;
      do_load(3'd1, 3'd0, "abort_pin");
      push_frame(16'hA89F, "abort_pin");
      check_frame();
      repeat (250) step();
      chk("abort_no_done", 32'(done_cnt), 32'(d0));

      // reset in the middle of a countdown
      do_load(3'd4, 3'd2, "rst_cont");
      repeat (50) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstcont_an", 32'(bus.an), 32'd0);
      chk("rstcont_code", 32'(bus.code), 32'd15);
      d0 = done_cnt;
      repeat (300) step();
      chk("rstcont_no_done", 32'(done_cnt), 32'(d0));
      push_frame(16'hFFFF, "rstcont_blank");
      check_frame();

      // reset and load on the same edge: load ignored
      do_load(3'd1, 3'd0, "pre_rst");
      rst         = 1'b1;
      bus.load    = 1'b1;
      bus.msg_sel = 3'd0;
      bus.credito = 3'd3;
      step();
      bus.load = 1'b0;
      rst      = 1'b0;
      chk("rstload_ack0", 32'(bus.ack), 32'd0);
      step();
      chk("rstload_ack1", 32'(bus.ack), 32'd0);
      push_frame(16'hFFFF, "rstload_blank");
      check_frame();
      do_load(3'd0, 3'd7, "cred7_after_rst");
      push_frame(16'h6FFF, "cred7_after_rst");
      check_frame();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
